// File: rtl/tx_lane_scheduler.sv
// tx_lane_scheduler: shares one lane serializer between two packet sources.
// Sends TRAIN_LEN COM (0xBC) bytes after reset, then grants the lane per packet
// round-robin, inserts one COM byte between packets and aborts stalled packets.
// Optional feature macro: TX_SCHED_STATS_EN (packet/abort statistics counters).
module tx_lane_scheduler #(
  parameter int unsigned TRAIN_LEN = 4,
  parameter int unsigned MAX_STALL = 8
) (
  input  logic       clock4,
  input  logic       reset_L,
  input  logic       valid0,
  input  logic       valid1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  input  logic       last0,
  input  logic       last1,
  output logic       ready0,
  output logic       ready1,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       abort_out,
  output logic       train_done
`ifdef TX_SCHED_STATS_EN
  ,
  output logic [15:0] pkt_count0,
  output logic [15:0] pkt_count1,
  output logic [7:0]  abort_count
`endif
);

  localparam logic [7:0] COM        = 8'hBC;
  localparam logic [7:0] TRAIN_LAST = 8'(TRAIN_LEN - 1);
  localparam logic [7:0] STALL_LAST = 8'(MAX_STALL - 1);

  typedef enum logic [1:0] {TRAIN, IDLE, SEND, GAP} state_t;

  state_t     state, state_nx;
  logic [7:0] train_cnt, train_cnt_nx;
  logic [7:0] stall_cnt, stall_cnt_nx;
  logic       grant, grant_nx;
  logic       last_grant, last_grant_nx;
  logic [7:0] data_nx;
  logic       valid_nx, abort_nx, train_done_nx;
  logic       sel_valid, sel_last;
  logic [7:0] sel_data;

  assign ready0    = (state == SEND) && !grant;
  assign ready1    = (state == SEND) && grant;
  assign sel_valid = grant ? valid1 : valid0;
  assign sel_data  = grant ? data1  : data0;
  assign sel_last  = grant ? last1  : last0;

  // Next-state and next-output decode; outputs are registered one cycle later.
  always_comb begin
    state_nx      = state;
    train_cnt_nx  = train_cnt;
    stall_cnt_nx  = stall_cnt;
    grant_nx      = grant;
    last_grant_nx = last_grant;
    data_nx       = COM;
    valid_nx      = 1'b0;
    abort_nx      = 1'b0;
    train_done_nx = train_done;
    case (state)
      TRAIN: begin
        if (train_cnt == TRAIN_LAST) begin
          state_nx      = IDLE;
          train_cnt_nx  = '0;
          train_done_nx = 1'b1;
        end else begin
          train_cnt_nx = train_cnt + 8'd1;
        end
      end
      IDLE: begin
        if (valid0 || valid1) begin
          grant_nx      = (valid0 && valid1) ? !last_grant : valid1;
          last_grant_nx = grant_nx;
          state_nx      = SEND;
        end
      end
      SEND: begin
        if (sel_valid) begin
          data_nx      = sel_data;
          valid_nx     = 1'b1;
          stall_cnt_nx = '0;
          if (sel_last) state_nx = GAP;
        end else if (stall_cnt == STALL_LAST) begin
          abort_nx     = 1'b1;
          stall_cnt_nx = '0;
          state_nx     = GAP;
        end else begin
          stall_cnt_nx = stall_cnt + 8'd1;
        end
      end
      GAP:     state_nx = IDLE;
      default: state_nx = TRAIN;
    endcase
  end

  // State and registered outputs with synchronous active-low reset.
  always_ff @(posedge clock4) begin
    if (!reset_L) begin
      state      <= TRAIN;
      train_cnt  <= '0;
      stall_cnt  <= '0;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      data_out   <= COM;
      valid_out  <= 1'b0;
      abort_out  <= 1'b0;
      train_done <= 1'b0;
    end else begin
      state      <= state_nx;
      train_cnt  <= train_cnt_nx;
      stall_cnt  <= stall_cnt_nx;
      grant      <= grant_nx;
      last_grant <= last_grant_nx;
      data_out   <= data_nx;
      valid_out  <= valid_nx;
      abort_out  <= abort_nx;
      train_done <= train_done_nx;
    end
  end

`ifdef TX_SCHED_STATS_EN
  logic pkt_end0, pkt_end1;

  // A packet completes when its last byte is accepted.
  always_comb begin
    pkt_end0 = ready0 && valid0 && last0;
    pkt_end1 = ready1 && valid1 && last1;
  end

  // Wrapping statistics counters.
  always_ff @(posedge clock4) begin
    if (!reset_L) begin
      pkt_count0  <= '0;
      pkt_count1  <= '0;
      abort_count <= '0;
    end else begin
      if (pkt_end0) pkt_count0 <= pkt_count0 + 16'd1;
      if (pkt_end1) pkt_count1 <= pkt_count1 + 16'd1;
      if (abort_nx && (state == SEND)) abort_count <= abort_count + 8'd1;
    end
  end
`endif

endmodule

// File: doc/tx_lane_scheduler.md
# tx_lane_scheduler

Byte-rate transmit scheduler that shares the single PCIe lane serializer between two packet sources. After reset it holds the lane in a COM (0xBC) training sequence, then grants the lane to one requester per packet using round-robin arbitration, inserting one COM idle byte between packets and aborting stalled packets. It sits directly upstream of the parallel-to-serial stage, in the clock4 domain, and produces the same data/valid byte stream the receive-side deserializer recovers.

## Interface
- `TRAIN_LEN`, 4: number of COM bytes sent after reset before arbitration starts (1..255).
- `MAX_STALL`, 8: consecutive bubble cycles tolerated inside a packet before abort (1..255).
- `clock4` in 1: byte clock; all logic on its rising edge.
- `reset_L` in 1: reset, synchronous and active-low.
- `valid0`, `valid1` in 1: requester byte valid.
- `data0`, `data1` in 8: requester byte.
- `last0`, `last1` in 1: byte is the final byte of the packet.
- `ready0`, `ready1` out 1: byte accepted this cycle when `validN & readyN`.
- `data_out` out 8: byte to serializer; 0xBC whenever `valid_out`=0.
- `valid_out` out 1: `data_out` carries payload.
- `abort_out` out 1: one-cycle pulse when a packet is aborted for stall.
- `train_done` out 1: high once training completes; stays high until reset.

## Operation
- States: TRAIN, IDLE, SEND, GAP.
- Reset (`reset_L`=0 at an edge): state TRAIN, train counter 0, stall counter 0, `last_grant`=1, `data_out`=0xBC, `valid_out`=0, `abort_out`=0, `train_done`=0. Reset mid-packet drops the packet without an abort pulse.
- TRAIN: emit 0xBC/valid 0 for `TRAIN_LEN` cycles, then IDLE and set `train_done`.
- IDLE: emit 0xBC. If either valid is high, latch grant and go SEND. Both valid: grant = !`last_grant`. One valid: grant to it. `last_grant` updates to the granted port.
- SEND: `readyN` = (state==SEND) & (grant==N), combinational; the non-granted ready is 0. On transfer: `data_out`<=dataN, `valid_out`<=1, stall counter cleared. If `lastN` is high, go GAP. On bubble (granted valid low): emit 0xBC/valid 0 and increment the stall counter. When the counter reaches `MAX_STALL`, pulse `abort_out`, go GAP, clear the counter.
- GAP: exactly one 0xBC/valid 0 byte, then IDLE. Guarantees at least one COM between packets.
- Valid on the non-granted port during SEND is ignored and not lost; the requester holds it.

## Timing
- All outputs are registered except `ready0`/`ready1`.
- Valid asserted in IDLE at cycle t: SEND at t+1 with ready high, first byte on `data_out` at t+2.
- Accepted byte at cycle t appears on `data_out` at t+1.
- Back-to-back packets: last byte out at t+1, GAP byte at t+2, IDLE at t+2, next SEND at t+3, next payload at t+4.
- `abort_out` is high in the cycle after the `MAX_STALL`-th consecutive bubble. The granted ready drops the same cycle, because the state is already GAP.
- `train_done` rises together with the first IDLE cycle.

## Configuration
- `TX_SCHED_STATS_EN` defined: adds outputs `pkt_count0`/`pkt_count1` (16-bit each) and `abort_count` (8-bit), all reset to 0.
  - `pkt_countN` increments on each transfer with `lastN`=1.
  - `abort_count` increments on each abort.
  - All counters wrap (0xFFFF→0, 0xFF→0).
- Undefined: those ports and counters do not exist; all other behaviour is identical.

## Test plan
- Reset with `TRAIN_LEN`=4 → exactly 4 cycles of 0xBC/valid 0 with `train_done`=0, then `train_done`=1 and continuous 0xBC idle.
- Port0 sends 3-byte packet 0x11,0x22,0x33 (last on 0x33) → `data_out` 0x11,0x22,0x33 with valid 1 on consecutive cycles, first at t+2, then one 0xBC gap.
- Both ports valid continuously with 2-byte packets → grants alternate 0,1,0,1 (port0 first after reset), with exactly one 0xBC between packets.
- Port1 mid-packet deasserts valid for `MAX_STALL`=8 cycles → 8 bubble bytes 0xBC, then a 1-cycle `abort_out` pulse and GAP. Port0 is then granted if valid.
- `reset_L` low during SEND → next cycle `data_out`=0xBC, `valid_out`=0, readys 0, no abort pulse, TRAIN restarts.
- With `TX_SCHED_STATS_EN`, preload `pkt_count0` near wrap: 0xFFFF packets then one more on port0 → `pkt_count0`=0. One abort → `abort_count`=1.
